// File: rtl/bitonic_sort_pipe.sv
// Fully pipelined bitonic sorting network: one N-key vector per cycle, per-vector direction,
// valid/ready with global stall. Optional signed compare with BITONIC_SIGNED_EN (adds port in_signed).
module bitonic_sort_pipe #(
  parameter int N = 8,
  parameter int W = 32,
  localparam int LOGN = (N > 2) ? $clog2(N) : 1,
  localparam int STAGES = LOGN * (LOGN + 1) / 2,
  localparam int OCC_W = $clog2(STAGES + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_dir,
`ifdef BITONIC_SIGNED_EN
  input  logic             in_signed,
`endif
  input  logic [N*W-1:0]   in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_dir,
  output logic [N*W-1:0]   out_data,
  output logic [OCC_W-1:0] occupancy
);

  function automatic logic key_gt(input logic [W-1:0] a, input logic [W-1:0] b, input logic sgn);
    if (sgn) begin
      return $signed(a) > $signed(b);
    end else begin
      return a > b;
    end
  endfunction

  // One network column: partner distance 2^q, block direction from bit p+1 of the lower index.
  function automatic logic [N*W-1:0] cx_column(input logic [N*W-1:0] d, input logic dir,
                                               input logic sgn, input int p, input int q);
    logic [N*W-1:0] r;
    r = d;
    for (int i = 0; i < N; i++) begin
      int j;
      int lo;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic desc;
      logic sw;
      j    = i ^ (1 << q);
      lo   = (i < j) ? i : j;
      a    = d[lo*W +: W];
      b    = d[(i ^ j ^ lo)*W +: W];
      desc = lo[p+1] ^ dir;
      sw   = desc ? key_gt(b, a, sgn) : key_gt(a, b, sgn);
      r[i*W +: W] = sw ? d[j*W +: W] : d[i*W +: W];
    end
    return r;
  endfunction

  logic [N*W-1:0]   data_r   [STAGES];
  logic [N*W-1:0]   col_in_s [STAGES];
  logic [N*W-1:0]   col_s    [STAGES];
  logic [STAGES-1:0] valid_r, dir_r, sgn_r;
  logic [STAGES-1:0] col_dir_s, col_sgn_s;
  logic [OCC_W-1:0]  occ_r;
  logic advance_s, acc_s, xfer_s, sgn_in_s, sgn_unused_s;

`ifdef BITONIC_SIGNED_EN
  assign sgn_in_s = in_signed;
`else
  assign sgn_in_s = 1'b0;
`endif
  // The last stage's sign bit has no consumer.
  assign sgn_unused_s = sgn_r[STAGES-1];

  assign advance_s = !valid_r[STAGES-1] | out_ready;
  assign in_ready  = rst & advance_s;
  assign acc_s     = in_valid & in_ready;
  assign xfer_s    = valid_r[STAGES-1] & out_ready;

  for (genvar p = 0; p < LOGN; p++) begin : g_p
    for (genvar r = 0; r <= p; r++) begin : g_r
      localparam int S = p * (p + 1) / 2 + r;
      localparam int Q = p - r;
      if (S == 0) begin : g_first
        assign col_in_s[S]  = in_data;
        assign col_dir_s[S] = in_dir;
        assign col_sgn_s[S] = sgn_in_s;
      end else begin : g_next
        assign col_in_s[S]  = data_r[S-1];
        assign col_dir_s[S] = dir_r[S-1];
        assign col_sgn_s[S] = sgn_r[S-1];
      end
      assign col_s[S] = cx_column(col_in_s[S], col_dir_s[S], col_sgn_s[S], p, Q);
    end
  end

  // Stage registers: whole pipe shifts together on advance, otherwise holds.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_r <= '0;
      dir_r   <= '0;
      sgn_r   <= '0;
      for (int s = 0; s < STAGES; s++) data_r[s] <= '0;
    end else if (advance_s) begin
      valid_r[0] <= in_valid;
      for (int s = 1; s < STAGES; s++) valid_r[s] <= valid_r[s-1];
      dir_r <= col_dir_s;
      sgn_r <= col_sgn_s;
      for (int s = 0; s < STAGES; s++) data_r[s] <= col_s[s];
    end
  end

  // In-flight count tracks accepts against output transfers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      occ_r <= '0;
    end else begin
      case ({acc_s, xfer_s})
        2'b10:   occ_r <= occ_r + OCC_W'(1);
        2'b01:   occ_r <= occ_r - OCC_W'(1);
        default: occ_r <= occ_r;
      endcase
    end
  end

  assign out_valid = valid_r[STAGES-1];
  assign out_dir   = dir_r[STAGES-1];
  assign out_data  = data_r[STAGES-1];
  assign occupancy = occ_r;

endmodule

// File: tb/tb_bitonic_sort_pipe.sv
// Scoreboard bench for bitonic_sort_pipe (N=8, W=32); signed vectors only with BITONIC_SIGNED_EN.
module tb_bitonic_sort_pipe;
  localparam int N = 8;
  localparam int W = 32;
  localparam int STAGES = 6;

  typedef logic [W-1:0] kv_t [N];
  typedef struct {
    logic [N*W-1:0] data;
    logic           dir;
    int             cyc;
    bit             lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst, in_valid, in_ready, in_dir, out_valid, out_ready, out_dir;
  logic [N*W-1:0] in_data, out_data;
  logic [2:0] occupancy;
`ifdef BITONIC_SIGNED_EN
  logic in_signed;
`endif

  exp_t sb_q[$];
  exp_t mon_e;
  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int occ_peak = 0;

  bitonic_sort_pipe #(.N(N), .W(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_dir(in_dir),
`ifdef BITONIC_SIGNED_EN
    .in_signed(in_signed),
`endif
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready), .out_dir(out_dir),
    .out_data(out_data), .occupancy(occupancy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [N*W-1:0] pk(input kv_t k);
    logic [N*W-1:0] r;
    for (int i = 0; i < N; i++) r[i*W +: W] = k[i];
    return r;
  endfunction

  task automatic check(input string nm, input logic [N*W-1:0] act, input logic [N*W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic send(input kv_t k, input logic d, input logic sg, input kv_t ek, input bit lat);
    exp_t e;
    bit ok;
    ok = 1'b0;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = pk(k);
    in_dir   = d;
`ifdef BITONIC_SIGNED_EN
    in_signed = sg;
`else
    if (sg) $display("note: signed request sent to unsigned build");
`endif
    for (int g = 0; g < 100; g++) begin
      #1;
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: in_ready got 0 expected 1");
    end else begin
      e.data = pk(ek);
      e.dir  = d;
      e.cyc  = cyc;
      e.lat  = lat;
      sb_q.push_back(e);
    end
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    bit ok;
    ok = 1'b0;
    for (int g = 0; g < 100; g++) begin
      @(negedge clk);
      #3;
      if (sb_q.size() == 0 && !out_valid) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: pending got %0d expected 0", sb_q.size());
    end
    check("occupancy_idle", occupancy, 0);
  endtask

  // Monitor: pops the scoreboard whenever an output transfer is about to happen.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (int'(occupancy) > occ_peak) occ_peak = int'(occupancy);
      if (rst === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: got %h expected none", out_data);
        end else begin
          mon_e = sb_q.pop_front();
          check("out_data", out_data, mon_e.data);
          check("out_dir", out_dir, mon_e.dir);
          if (mon_e.lat) check("latency", cyc - mon_e.cyc, STAGES);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time got limit expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    kv_t pat, pat_asc, pat_dsc, k, ek;
    rst = 1'b0; in_valid = 1'b0; in_dir = 1'b0; in_data = '0; out_ready = 1'b1;
`ifdef BITONIC_SIGNED_EN
    in_signed = 1'b0;
`endif
    repeat (2) @(negedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_occupancy", occupancy, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_dir", out_dir, 0);
    @(negedge clk);
    rst = 1'b1;

    pat     = '{32'd7, 32'd3, 32'd9, 32'd0, 32'd5, 32'd5, 32'd1, 32'd8};
    pat_asc = '{32'd0, 32'd1, 32'd3, 32'd5, 32'd5, 32'd7, 32'd8, 32'd9};
    pat_dsc = '{32'd9, 32'd8, 32'd7, 32'd5, 32'd5, 32'd3, 32'd1, 32'd0};

    send(pat, 1'b0, 1'b0, pat_asc, 1'b1);
    idle();
    drain();

    send('{32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd7, 32'd8}, 1'b1, 1'b0,
         '{32'd8, 32'd7, 32'd6, 32'd5, 32'd4, 32'd3, 32'd2, 32'd1}, 1'b1);
    send('{32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd7, 32'd8}, 1'b0, 1'b0,
         '{32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd7, 32'd8}, 1'b1);
    idle();
    drain();

    send('{32'hFFFFFFFF, 32'h0, 32'hFFFFFFFF, 32'h0, 32'h80000000, 32'h7FFFFFFF, 32'h0, 32'h1}, 1'b0, 1'b0,
         '{32'h0, 32'h0, 32'h0, 32'h1, 32'h7FFFFFFF, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF}, 1'b1);
    send('{32'd3, 32'd3, 32'd1, 32'd1, 32'd2, 32'd2, 32'd0, 32'd0}, 1'b1, 1'b0,
         '{32'd3, 32'd3, 32'd2, 32'd2, 32'd1, 32'd1, 32'd0, 32'd0}, 1'b1);
    send('{32'h80000000, 32'h7FFFFFFF, 32'hFFFFFFFF, 32'h0, 32'h1, 32'h2, 32'h3, 32'h4}, 1'b0, 1'b0,
         '{32'h0, 32'h1, 32'h2, 32'h3, 32'h4, 32'h7FFFFFFF, 32'h80000000, 32'hFFFFFFFF}, 1'b1);
`ifdef BITONIC_SIGNED_EN
    send('{32'h80000000, 32'h7FFFFFFF, 32'hFFFFFFFF, 32'h0, 32'h1, 32'h2, 32'h3, 32'h4}, 1'b0, 1'b1,
         '{32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h1, 32'h2, 32'h3, 32'h4, 32'h7FFFFFFF}, 1'b1);
    send('{32'h80000000, 32'h7FFFFFFF, 32'hFFFFFFFF, 32'h0, 32'h1, 32'h2, 32'h3, 32'h4}, 1'b1, 1'b1,
         '{32'h7FFFFFFF, 32'h4, 32'h3, 32'h2, 32'h1, 32'h0, 32'hFFFFFFFF, 32'h80000000}, 1'b1);
`endif
    idle();
    drain();

    // Backpressure: stream 10 vectors while the consumer stalls for 4 cycles.
    occ_peak = 0;
    fork
      begin
        for (int v = 0; v < 10; v++) begin
          for (int i = 0; i < N; i++) begin
            k[i]  = pat[i] + 32'(16 * v);
            ek[i] = ((v % 2) == 1) ? pat_dsc[i] + 32'(16 * v) : pat_asc[i] + 32'(16 * v);
          end
          send(k, 1'(v % 2), 1'b0, ek, 1'b0);
        end
        idle();
      end
      begin
        logic [N*W-1:0] hold;
        bit seen;
        seen = 1'b0;
        for (int g = 0; g < 100; g++) begin
          @(negedge clk);
          #1;
          if (out_valid) begin
            seen = 1'b1;
            break;
          end
        end
        if (!seen) begin
          checks++;
          errors++;
          $display("FAIL bp_first_output: out_valid got 0 expected 1");
        end
        @(negedge clk);
        out_ready = 1'b0;
        #1;
        hold = out_data;
        for (int c = 0; c < 4; c++) begin
          if (c > 0) begin
            @(negedge clk);
            #1;
          end
          check("bp_in_ready", in_ready, 0);
          check("bp_out_valid", out_valid, 1);
          check("bp_out_stable", out_data, hold);
        end
        @(negedge clk);
        out_ready = 1'b1;
      end
    join
    drain();
    check("bp_occ_peak", occ_peak, STAGES);

    // Reset with three vectors in flight: none may appear.
    send(pat, 1'b0, 1'b0, pat_asc, 1'b0);
    send(pat, 1'b1, 1'b0, pat_dsc, 1'b0);
    send(pat, 1'b0, 1'b0, pat_asc, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b0;
    sb_q.delete();
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_occupancy", occupancy, 0);
    check("midrst_in_ready", in_ready, 0);
    @(negedge clk);
    rst = 1'b1;
    repeat (10) @(negedge clk);
    check("midrst_idle_occ", occupancy, 0);
    send(pat, 1'b0, 1'b0, pat_asc, 1'b1);
    idle();
    drain();

    check("scoreboard_empty", sb_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/bitonic_sort_pipe.md
Name: bitonic_sort_pipe

Overview:
- Fully pipelined bitonic sorting network for N keys of W bits each. Next generation of the two-input compare-exchange sorter.
- Accepts one N-key vector per cycle with a per-vector sort direction.
- Registers every compare-exchange stage.
- Uses valid/ready handshakes on input and output with full backpressure.
- Sits between a vector producer (scan/gather unit) and a downstream consumer that needs ordered keys.

Parameters:
- N, 8, number of keys per vector; power of two, 2..32.
- W, 32, key width in bits.
- STAGES, derived (not overridable), log2(N)*(log2(N)+1)/2; equals 6 for N=8.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-low reset.
- in_valid  input  1  input vector valid.
- in_ready  output  1  block can accept a vector this cycle.
- in_dir  input  1  0 = ascending (key 0 smallest), 1 = descending; sampled with the vector.
- in_data  input  N*W  key i at bits [i*W +: W].
- out_valid  output  1  sorted vector valid.
- out_ready  input  1  consumer accepts this cycle.
- out_dir  output  1  direction the output vector was sorted with.
- out_data  output  N*W  sorted keys, same packing as in_data.
- occupancy  output  $clog2(STAGES+1)  number of valid vectors in flight.

Behaviour:
- Reset (rst low, async assert, synchronous release at the next clk edge after rst rises):
  - all stage valid bits, out_valid, out_dir, out_data and occupancy = 0.
  - in_ready = 0 while rst is low.
- Pipeline:
  - STAGES register stages; each stage is one column of the bitonic network: N/2 compare-exchanges.
  - Stage k holds data, dir and a valid bit.
  - Dir travels with its vector; vectors of different direction may be interleaved back to back.
- Compare-exchange:
  - Unsigned magnitude compare.
  - Each comparator's orientation = network-position direction XOR vector dir.
  - Equal keys never swap.
- Advance:
  - advance = !out_valid | out_ready.
  - When advance is 1, every stage loads from its predecessor; stage 0 loads in_data and in_dir, with valid = in_valid.
  - When advance is 0, all stages hold (global stall); no bubble collapsing.
- Handshake:
  - in_ready = advance (combinational from out_valid/out_ready); a vector is taken when in_valid & in_ready.
  - out_valid and out_data stay stable while out_valid & !out_ready.
  - in_valid low while advancing inserts a bubble.
- Latency:
  - A vector accepted at edge t appears with out_valid=1 after edge t+STAGES-1, i.e. STAGES cycles to the output register, when there is no stall.
  - Throughput is 1 vector/cycle.
- Occupancy:
  - Count of set stage-valid bits, registered.
  - +1 on accept without output transfer; −1 on output transfer without accept; unchanged when both or neither happen.
  - Never exceeds STAGES.
- Boundaries:
  - Pipeline full with out_ready=0 holds in_ready=0; in_valid held high loses no data.
  - Simultaneous accept and output transfer in the same cycle is legal.
  - Reset mid-operation discards all in-flight vectors; there is no partial output.
  - N=2 degenerates to a single registered compare-exchange, STAGES=1.

Optional Feature:
- Macro: BITONIC_SIGNED_EN.
- Defined:
  - Keys compare as two's-complement signed W-bit values.
  - Extra input port in_signed (1 bit) is sampled with the vector and carried with it.
  - in_signed=1 selects a signed compare for that vector; in_signed=0 selects unsigned.
- Undefined:
  - Port in_signed is absent.
  - All compares are unsigned.

Test Plan:
- Reset then single vector:
  - Stimulus: N=8, in_dir=0, keys {7,3,9,0,5,5,1,8} (key0..key7), out_ready=1.
  - Response: out_valid after 6 cycles with {0,1,3,5,5,7,8,9}; occupancy back to 0.
- Descending back to back:
  - Stimulus: vector A {1,2,3,4,5,6,7,8} dir=1, then the same keys dir=0 on the next cycle.
  - Response: consecutive outputs {8,7,6,5,4,3,2,1} with out_dir=1, then {1..8} with out_dir=0.
- Backpressure:
  - Stimulus: stream 10 distinct vectors; drop out_ready for 4 cycles once out_valid is 1.
  - Response: in_ready=0 throughout; out_data stable; no loss or duplication; occupancy peaks at 6.
- Extremes and ties:
  - Stimulus: keys {FFFFFFFF,0,FFFFFFFF,0,80000000,7FFFFFFF,0,1}, dir=0, unsigned.
  - Response: {0,0,0,1,7FFFFFFF,80000000,FFFFFFFF,FFFFFFFF}.
- Reset mid-flight:
  - Stimulus: accept 3 vectors, assert rst low for 1 cycle after the 2nd cycle.
  - Response: out_valid never asserts for them; occupancy=0; the next vector sorts correctly with 6-cycle latency.
- BITONIC_SIGNED_EN, in_signed=1:
  - Stimulus: keys {80000000,7FFFFFFF,FFFFFFFF,0,1,2,3,4}, dir=0.
  - Response: {80000000,FFFFFFFF,0,1,2,3,4,7FFFFFFF}.
